// File: rtl/alu_cond_if.sv
// alu_cond_if: request/response bundle between a condition requester and
// alu_cond_unit.
//   cond_valid/cond_ready : request handshake (code + tag)
//   res_valid/res_ready   : response handshake (taken, err, tag)
// Modports: master = requester/consumer side, slave = alu_cond_unit.
interface alu_cond_if #(
  parameter int TAG_W = 4
);
  logic             cond_valid;
  logic             cond_ready;
  logic [3:0]       cond_code;
  logic [TAG_W-1:0] cond_tag;
  logic             res_valid;
  logic             res_ready;
  logic             res_taken;
  logic             res_err;
  logic [TAG_W-1:0] res_tag;

  modport master (
    output cond_valid, cond_code, cond_tag, res_ready,
    input  cond_ready, res_valid, res_taken, res_err, res_tag
  );

  modport slave (
    input  cond_valid, cond_code, cond_tag, res_ready,
    output cond_ready, res_valid, res_taken, res_err, res_tag
  );
endinterface

// File: rtl/alu_cond_unit.sv
// alu_cond_unit: captures ALU {N,Z,C,V} flags into an architectural flag
// register and evaluates 4-bit condition codes against them, returning one
// registered response per accepted request. Saturating counters track
// accepted requests and taken results.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   flag_valid, flag_n/z/c/v  flag update strobe and ALU flags
//   bus (alu_cond_if.slave)   condition request / response handshake
//   flags_q               architectural flags {N,Z,C,V}
//   eval_cnt, taken_cnt   saturating statistics
//
// Build option: ALU_COND_FWD_EN -- when defined, a request arriving on the
// same cycle as a flag update is evaluated against the incoming flags;
// otherwise the request is stalled for that cycle (cond_ready forced low).
//
// state | meaning
// ------+---------------------------------------------------
// EMPTY | no response held, res_valid=0
// FULL  | response held in res_* registers, res_valid=1
module alu_cond_unit #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flag_valid,
  input  logic             flag_n,
  input  logic             flag_z,
  input  logic             flag_c,
  input  logic             flag_v,
  alu_cond_if.slave        bus,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] eval_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [3:0]       flags_in;
  logic [3:0]       eval_flags;
  logic             accept;
  logic             cond_true;
  logic             cond_err;
  logic             res_taken_q;
  logic             res_err_q;
  logic [TAG_W-1:0] res_tag_q;
  logic [CNT_W-1:0] eval_cnt_q, eval_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    r = 1'b0;
    case (code)
      4'h0: r = z;
      4'h1: r = !z;
      4'h2: r = c;
      4'h3: r = !c;
      4'h4: r = n;
      4'h5: r = !n;
      4'h6: r = v;
      4'h7: r = !v;
      4'h8: r = c & !z;
      4'h9: r = !c | z;
      4'hA: r = (n == v);
      4'hB: r = (n != v);
      4'hC: r = !z & (n == v);
      4'hD: r = z | (n != v);
      4'hE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign flags_in = {flag_n, flag_z, flag_c, flag_v};

`ifdef ALU_COND_FWD_EN
  // Forward the incoming flags so a same-cycle request sees the newest values.
  assign eval_flags     = flag_valid ? flags_in : flags_q;
  assign bus.cond_ready = (state_q == EMPTY) | bus.res_ready;
`else
  // Stall requests during a flag update; they are taken next cycle against
  // the freshly registered flags.
  assign eval_flags     = flags_q;
  assign bus.cond_ready = ((state_q == EMPTY) | bus.res_ready) & !flag_valid;
`endif

  assign accept    = bus.cond_valid & bus.cond_ready;
  assign cond_true = cond_eval(bus.cond_code, eval_flags);
  assign cond_err  = (bus.cond_code == 4'hF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (bus.res_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    eval_cnt_d  = eval_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (accept && eval_cnt_q != CNT_MAX) eval_cnt_d = eval_cnt_q + CNT_ONE;
    if (accept && cond_true && taken_cnt_q != CNT_MAX) taken_cnt_d = taken_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q     <= 4'b0;
      res_taken_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_tag_q   <= '0;
      eval_cnt_q  <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (flag_valid) flags_q <= flags_in;
      if (accept) begin
        res_taken_q <= cond_true;
        res_err_q   <= cond_err;
        res_tag_q   <= bus.cond_tag;
      end
      eval_cnt_q  <= eval_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign bus.res_valid = (state_q == FULL);
  assign bus.res_taken = res_taken_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_tag   = res_tag_q;
  assign eval_cnt      = eval_cnt_q;
  assign taken_cnt     = taken_cnt_q;

endmodule
